// File: rtl/bhv_sram_bw.sv
// Behavioural 1R/1W SRAM: per-byte write enables, write-first collision forwarding, hardware zero-clear.
// Read latency RLAT (1 or 2) cycles, fully pipelined; a clear sequence takes DEPTH cycles.
// No backpressure: one read and one write accepted per cycle in READY; all requests dropped while busy.
//
// Ports:
//   clk, rst_n         : clock (rising edge) and async active-low reset
//   init               : restart the zero-clear sequence
//   busy               : clear sequence in progress, port requests ignored
//   aa, cena, qa, qa_vld : read address, read enable (low), read data, read-data valid pulse
//   ab, cenb, db, bwenb  : write address, write enable (low), write data, byte enables (low)
//   werr               : sticky out-of-range write flag, cleared by reset or init
module bhv_sram_bw #(
  parameter int WWORD = 32,
  parameter int WADDR = 5,
  parameter int DEPTH = 24,
  parameter int RLAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init,
  output logic               busy,
  output logic [WWORD-1:0]   qa,
  output logic               qa_vld,
  input  logic [WADDR-1:0]   aa,
  input  logic               cena,
  input  logic [WWORD-1:0]   db,
  input  logic [WADDR-1:0]   ab,
  input  logic               cenb,
  input  logic [WWORD/8-1:0] bwenb,
  output logic               werr
);

  localparam int NB = WWORD / 8;
  // One extra bit so DEPTH == 2**WADDR is representable in the range compare.
  localparam logic [WADDR:0]   DEPTH_W = (WADDR + 1)'(DEPTH);
  localparam logic [WADDR-1:0] LAST    = WADDR'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t           state;
  logic [WADDR-1:0] cnt;
  logic [WWORD-1:0] mem [0:DEPTH-1];

  logic             port_en;
  logic             rd_req;
  logic             wr_req;
  logic             aa_ok;
  logic             ab_ok;
  logic [WWORD-1:0] wr_old;
  logic [WWORD-1:0] wr_word;
  logic [WWORD-1:0] rd_dat;

  function automatic logic [WWORD-1:0] byte_merge(input logic [WWORD-1:0] old_w,
                                                  input logic [WWORD-1:0] new_w,
                                                  input logic [NB-1:0]    be_n);
    logic [WWORD-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (!be_n[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // An init edge in READY pre-empts both ports for that cycle.
  assign port_en = (state == S_READY) && !init;
  assign rd_req  = port_en && !cena;
  assign wr_req  = port_en && !cenb;
  assign aa_ok   = {1'b0, aa} < DEPTH_W;
  assign ab_ok   = {1'b0, ab} < DEPTH_W;

  always_comb begin
    wr_old = '0;
    if (ab_ok) wr_old = mem[ab];
  end

  assign wr_word = byte_merge(wr_old, db, bwenb);

  // Write-first: a same-address read sees the merged word being written this cycle.
  always_comb begin
    rd_dat = '0;
    if (aa_ok) begin
      if (wr_req && (ab == aa)) rd_dat = wr_word;
      else                      rd_dat = mem[aa];
    end
  end

  // Storage has no reset; CLEAR sweeps it to zero instead.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)     mem[cnt] <= '0;
    else if (wr_req && ab_ok) mem[ab]  <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
      werr  <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (init) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= S_READY;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + WADDR'(1);
          end
        end
        S_READY: begin
          if (init) begin
            state <= S_CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
            werr  <= 1'b0;
          end else if (wr_req && !ab_ok) begin
            werr <= 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  generate
    if (RLAT == 2) begin : g_rlat2
      logic             s1_vld;
      logic [WWORD-1:0] s1_dat;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_vld <= 1'b0;
          s1_dat <= '0;
          qa_vld <= 1'b0;
          qa     <= '0;
        end else begin
          s1_vld <= rd_req;
          if (rd_req) s1_dat <= rd_dat;
          qa_vld <= s1_vld;
          if (s1_vld) qa <= s1_dat;
        end
      end
    end else begin : g_rlat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          qa_vld <= 1'b0;
          qa     <= '0;
        end else begin
          qa_vld <= rd_req;
          if (rd_req) qa <= rd_dat;
        end
      end
    end
  endgenerate

endmodule

// File: doc/bhv_sram_bw.md
# bhv_sram_bw

Parametrised 1-read/1-write behavioural SRAM for LeNet feature-map and weight buffers, with:
- per-byte write enables
- selectable read latency (1 or 2 cycles)
- write-first forwarding on same-address collisions
- hardware zero-initialisation after reset or on request
- a sticky out-of-range write error flag

It sits between the layer controllers and the datapath wherever a buffer must start from a known-zero state without a software clear loop.

## Interface
Parameters:
- WWORD, 32, data width in bits; must be a multiple of 8
- WADDR, 5, address width
- DEPTH, 24, number of implemented words; 1 ≤ DEPTH ≤ 2^WADDR
- RLAT, 1, read latency in cycles; legal values 1 or 2

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- init  in  1  request re-clear of memory; sampled while state is READY or CLEAR
- busy  out  1  high while the clear sequence runs; all port requests are ignored
- qa  out  WWORD  read data
- qa_vld  out  1  one-cycle pulse marking new data on qa
- aa  in  WADDR  read address
- cena  in  1  read enable, active-low
- db  in  WWORD  write data
- ab  in  WADDR  write address
- cenb  in  1  write enable, active-low
- bwenb  in  WWORD/8  byte write enables, active-low; bit i controls db[8i+7:8i]
- werr  out  1  sticky flag: a write was attempted to ab ≥ DEPTH

## Operation
- FSM states are CLEAR and READY.
- Reset state:
  - state = CLEAR, clear counter = 0
  - busy = 1, qa = 0, qa_vld = 0, werr = 0
  - all pipeline registers are 0
  - memory array is not reset.
- CLEAR:
  - each cycle writes 0 to mem[counter], then increments counter.
  - on the edge where counter == DEPTH-1 is written, go to READY and drop busy.
  - takes exactly DEPTH cycles.
  - init asserted during CLEAR restarts counter at 0.
- READY:
  - init = 1 at an edge: go to CLEAR, counter = 0, werr cleared.
  - any read or write in that same cycle is ignored.
- Write (READY, cenb = 0):
  - if ab < DEPTH, each byte i with bwenb[i] = 0 takes db byte i; other bytes are unchanged.
  - if ab ≥ DEPTH, memory is unchanged and werr ← 1; werr stays set until reset or init.
  - all bwenb bits = 1 is a legal no-op write (no werr if ab < DEPTH).
- Read (READY, cena = 0):
  - returns mem[aa], or 0 when aa ≥ DEPTH.
- Collision (cena = 0 and cenb = 0 with aa == ab < DEPTH):
  - write-first: read data is the byte merge of the old word with the enabled db bytes.
- During busy:
  - cena, cenb and bwenb are ignored; no werr updates.
  - reads issued in the cycle busy falls are honoured normally.
- qa holds its last value when no read completes.
  - It is never cleared except by rst_n.
- Reset mid-operation: rst_n low immediately forces every reset value and kills in-flight reads.
  - Memory contents are then undefined until the CLEAR sequence completes.

## Timing
- RLAT = 1: read sampled at edge N → qa updated and qa_vld = 1 after edge N, for one cycle.
- RLAT = 2: read sampled at edge N → qa and qa_vld after edge N+1.
  - The internal stage is pipelined: back-to-back reads give one result per cycle.
- Write sampled at edge N is visible to a non-colliding read sampled at edge N+1.
  - A colliding read at edge N sees it via forwarding.
- busy deasserts DEPTH cycles after rst_n rises, or after the init edge.
- werr rises on the edge after the offending write is sampled.
- No throughput limit: one read and one write per cycle, every cycle, in READY.

## Test plan
- Reset clear: write 0xFFFFFFFF everywhere, then pulse rst_n low → busy high 24 cycles; reading addresses 0..23 returns 0x00000000 with qa_vld pulses.
- Byte mask: write 0x11223344 to addr 5, then db = 0xAABBCCDD with bwenb = 4'b1010 → read addr 5 returns 0x11BB33DD.
- Collision: mem[3] = 0x0; in the same cycle write 0xDEADBEEF (bwenb = 0) and read addr 3 → qa = 0xDEADBEEF at RLAT latency.
- Range check: write to ab = 30 → memory unchanged, werr = 1 and stays 1; read aa = 30 → qa = 0, qa_vld = 1; init pulse → werr = 0, busy 24 cycles.
- Latency/pipeline with RLAT = 2: consecutive reads of addrs 0, 1, 2 holding 0xA, 0xB, 0xC → qa_vld high 3 cycles, starting 2 cycles after the first request, data A, B, C in order.
- Busy gating: during CLEAR, issue a write of 0x55 to addr 0 and init at cycle 10 → write discarded, counter restarts, busy lasts 24 more cycles, addr 0 reads 0.
